// File: rtl/axis_byte_packer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | axis_byte_packer : packs narrow AXI-Stream beats into dense words    |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
module axis_byte_packer #(
   parameter int IEW = 0,
   parameter int OEW = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   output logic                  i_tready,
   input  logic                  i_tvalid,
   input  logic [8*(1<<IEW)-1:0] i_tdata,
   input  logic [(1<<IEW)-1:0]   i_tkeep,
   input  logic                  i_tlast,
   input  logic                  o_tready,
   output logic                  o_tvalid,
   output logic [8*(1<<OEW)-1:0] o_tdata,
   output logic [(1<<OEW)-1:0]   o_tkeep,
   output logic                  o_tlast
);
   localparam int IB = 1 << IEW;
   localparam int OB = 1 << OEW;
   localparam int CW = OEW + 1;
   localparam int TW = OEW + 2;

   generate
      if (OEW < IEW) begin : g_param_check
         $error("axis_byte_packer: OEW must be >= IEW");
      end
   endgenerate

   typedef enum logic [0:0] {ST_ACC = 1'b0, ST_FLUSH = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [8*OB-1:0] acc_q, acc_d;
   logic            o_tvalid_q, o_tvalid_d;
   logic [8*OB-1:0] o_tdata_q, o_tdata_d;
   logic [OB-1:0]   o_tkeep_q, o_tkeep_d;
   logic            o_tlast_q, o_tlast_d;

   logic             slot_free;
   logic             accept;
   logic [TW-1:0]    n;
   logic [TW-1:0]    t;
   logic [16*OB-1:0] merged;

   function automatic logic [OB-1:0] keep_of(input logic [TW-1:0] cnt);
      logic [OB-1:0] k;
      for (int j = 0; j < OB; j++) k[j] = (TW'(j) < cnt);
      return k;
   endfunction

   function automatic logic [8*OB-1:0] data_of(input logic [8*OB-1:0] d, input logic [TW-1:0] cnt);
      logic [8*OB-1:0] m;
      for (int j = 0; j < OB; j++) m[8*j +: 8] = (TW'(j) < cnt) ? d[8*j +: 8] : 8'h00;
      return m;
   endfunction

   always_comb begin
      slot_free = ~o_tvalid_q | o_tready;
      i_tready  = (state_q == ST_ACC) & slot_free;
      accept    = i_tvalid & i_tready;

      n = '0;
      for (int k = 0; k < IB; k++) n = n + TW'(i_tkeep[k]);
      t = TW'(cnt_q) + n;

      // Two words of lanes: accumulated bytes followed by the new beat; upper half is the residue.
      merged = '0;
      for (int j = 0; j < OB; j++) begin
         if (TW'(j) < TW'(cnt_q)) merged[8*j +: 8] = acc_q[8*j +: 8];
      end
      for (int j = 0; j < 2*OB; j++) begin
         for (int k = 0; k < IB; k++) begin
            if ((TW'(k) < n) && (TW'(j) == TW'(cnt_q) + TW'(k))) merged[8*j +: 8] = i_tdata[8*k +: 8];
         end
      end

      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      o_tvalid_d = slot_free ? 1'b0 : o_tvalid_q;
      o_tdata_d  = o_tdata_q;
      o_tkeep_d  = o_tkeep_q;
      o_tlast_d  = o_tlast_q;

      if (state_q == ST_FLUSH) begin
         if (slot_free) begin
            o_tvalid_d = 1'b1;
            o_tdata_d  = data_of(acc_q, TW'(cnt_q));
            o_tkeep_d  = keep_of(TW'(cnt_q));
            o_tlast_d  = 1'b1;
            cnt_d      = '0;
            acc_d      = '0;
            state_d    = ST_ACC;
         end
      end else if (accept) begin
         if (!i_tlast) begin
            if (t < TW'(OB)) begin
               acc_d = merged[8*OB-1:0];
               cnt_d = CW'(t);
            end else begin
               o_tvalid_d = 1'b1;
               o_tdata_d  = merged[8*OB-1:0];
               o_tkeep_d  = '1;
               o_tlast_d  = 1'b0;
               acc_d      = merged[16*OB-1:8*OB];
               cnt_d      = CW'(t - TW'(OB));
            end
         end else if (t != '0) begin
            if (t <= TW'(OB)) begin
               o_tvalid_d = 1'b1;
               o_tdata_d  = data_of(merged[8*OB-1:0], t);
               o_tkeep_d  = keep_of(t);
               o_tlast_d  = 1'b1;
               acc_d      = '0;
               cnt_d      = '0;
            end else begin
               o_tvalid_d = 1'b1;
               o_tdata_d  = merged[8*OB-1:0];
               o_tkeep_d  = '1;
               o_tlast_d  = 1'b0;
               acc_d      = merged[16*OB-1:8*OB];
               cnt_d      = CW'(t - TW'(OB));
               state_d    = ST_FLUSH;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_ACC;
         cnt_q      <= '0;
         acc_q      <= '0;
         o_tvalid_q <= 1'b0;
         o_tdata_q  <= '0;
         o_tkeep_q  <= '0;
         o_tlast_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         o_tvalid_q <= o_tvalid_d;
         o_tdata_q  <= o_tdata_d;
         o_tkeep_q  <= o_tkeep_d;
         o_tlast_q  <= o_tlast_d;
      end
   end

   assign o_tvalid = o_tvalid_q;
   assign o_tdata  = o_tdata_q;
   assign o_tkeep  = o_tkeep_q;
   assign o_tlast  = o_tlast_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_byte_packer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_axis_byte_packer : byte-stream model bench, 1-byte and 2-byte in  |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
module tb_axis_byte_packer;
   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } word_t;

   logic clk;
   logic rstn;

   logic        a_irdy, a_ivld, a_ilast, a_ordy, a_ovld, a_olast;
   logic [7:0]  a_idata;
   logic [0:0]  a_ikeep;
   logic [31:0] a_odata;
   logic [3:0]  a_okeep;

   logic        b_irdy, b_ivld, b_ilast, b_ordy, b_ovld, b_olast;
   logic [15:0] b_idata;
   logic [1:0]  b_ikeep;
   logic [31:0] b_odata;
   logic [3:0]  b_okeep;

   axis_byte_packer #(.IEW(0), .OEW(2)) u_dut_a (
      .clk(clk), .rstn(rstn),
      .i_tready(a_irdy), .i_tvalid(a_ivld), .i_tdata(a_idata), .i_tkeep(a_ikeep), .i_tlast(a_ilast),
      .o_tready(a_ordy), .o_tvalid(a_ovld), .o_tdata(a_odata), .o_tkeep(a_okeep), .o_tlast(a_olast)
   );

   axis_byte_packer #(.IEW(1), .OEW(2)) u_dut_b (
      .clk(clk), .rstn(rstn),
      .i_tready(b_irdy), .i_tvalid(b_ivld), .i_tdata(b_idata), .i_tkeep(b_ikeep), .i_tlast(b_ilast),
      .o_tready(b_ordy), .o_tvalid(b_ovld), .o_tdata(b_odata), .o_tkeep(b_okeep), .o_tlast(b_olast)
   );

   int vectors = 0;
   int miscompares = 0;
   bit rand_bp = 0;

   logic [7:0] pend_a[$], pend_b[$];
   word_t      exp_a[$], exp_b[$], seen_a[$], seen_b[$];
   bit         hold_a = 0, hold_b = 0;
   logic [36:0] snap_a, snap_b;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: packet bytes form a stream cut into 4-byte words; the final piece of a packet carries tlast.
   task automatic model_beat(input int inst, input logic [15:0] d, input int n, input logic last);
      logic [7:0] p[$];
      word_t      o[$];
      word_t      w;
      int         c;
      if (inst == 0) p = pend_a; else p = pend_b;
      for (int k = 0; k < n; k++) p.push_back(d[8*k +: 8]);
      while (p.size() > 4 || (p.size() == 4 && !last) || (last && p.size() > 0)) begin
         c = (p.size() > 4) ? 4 : p.size();
         w = '0;
         for (int j = 0; j < c; j++) w.d[8*j +: 8] = p.pop_front();
         w.k = 4'((1 << c) - 1);
         w.l = last && (p.size() == 0);
         o.push_back(w);
      end
      if (inst == 0) begin
         pend_a = p;
         foreach (o[i]) exp_a.push_back(o[i]);
      end else begin
         pend_b = p;
         foreach (o[i]) exp_b.push_back(o[i]);
      end
   endtask

   task automatic out_word(input int inst, input word_t w);
      word_t e;
      if ((inst == 0 && exp_a.size() == 0) || (inst == 1 && exp_b.size() == 0)) begin
         vectors++;
         miscompares++;
         $display("FAIL dut%0d_word: got unexpected word %h, expected no word", inst, w);
      end else begin
         if (inst == 0) begin e = exp_a.pop_front(); seen_a.push_back(w); end
         else begin e = exp_b.pop_front(); seen_b.push_back(w); end
         check($sformatf("dut%0d_word", inst), 64'(w), 64'(e));
      end
   endtask

   always @(negedge clk) begin
      if (!rstn) begin
         pend_a.delete(); pend_b.delete(); exp_a.delete(); exp_b.delete();
         hold_a = 0; hold_b = 0;
      end else begin
         if (a_ivld && a_irdy) model_beat(0, {8'h00, a_idata}, int'(a_ikeep), a_ilast);
         if (b_ivld && b_irdy) model_beat(1, b_idata, $countones(b_ikeep), b_ilast);
         if (hold_a) check("a_stable", 64'({a_ovld, a_odata, a_okeep, a_olast}), 64'({1'b1, snap_a}));
         if (hold_b) check("b_stable", 64'({b_ovld, b_odata, b_okeep, b_olast}), 64'({1'b1, snap_b}));
         hold_a = a_ovld && !a_ordy;
         hold_b = b_ovld && !b_ordy;
         snap_a = {a_odata, a_okeep, a_olast};
         snap_b = {b_odata, b_okeep, b_olast};
         if (a_ovld && !a_ordy) check("a_irdy_blocked", 64'(a_irdy), 64'd0);
         if (b_ovld && !b_ordy) check("b_irdy_blocked", 64'(b_irdy), 64'd0);
         if (a_ovld && a_ordy) out_word(0, {a_odata, a_okeep, a_olast});
         if (b_ovld && b_ordy) out_word(1, {b_odata, b_okeep, b_olast});
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_bp) begin
            a_ordy = ($urandom_range(0, 2) != 0);
            b_ordy = ($urandom_range(0, 2) != 0);
         end
      end
   end

   task automatic send_a(input logic [7:0] d, input logic k, input logic l);
      bit got = 0;
      a_ivld = 1'b1; a_idata = d; a_ikeep = k; a_ilast = l;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk); got = a_irdy;
         @(posedge clk); #1;
      end
      a_ivld = 1'b0;
      if (!got) check("a_accept_timeout", 64'(got), 64'd1);
   endtask

   task automatic send_b(input logic [15:0] d, input logic [1:0] k, input logic l);
      bit got = 0;
      b_ivld = 1'b1; b_idata = d; b_ikeep = k; b_ilast = l;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk); got = b_irdy;
         @(posedge clk); #1;
      end
      b_ivld = 1'b0;
      if (!got) check("b_accept_timeout", 64'(got), 64'd1);
   endtask

   task automatic check_seen(input string name, input int inst, input int idx, input word_t e);
      word_t g;
      g = '0;
      if (inst == 0) begin if (idx < seen_a.size()) g = seen_a[idx]; end
      else begin if (idx < seen_b.size()) g = seen_b[idx]; end
      check(name, 64'(g), 64'(e));
   endtask

   task automatic rand_packets(input int inst, input int npkt);
      int nb, n;
      for (int p = 0; p < npkt; p++) begin
         nb = $urandom_range(1, 8);
         for (int b = 0; b < nb; b++) begin
            if (inst == 0) begin
               n = ($urandom_range(0, 4) == 0) ? 0 : 1;
               send_a(8'($urandom), n[0], b == nb - 1);
            end else begin
               n = $urandom_range(0, 2);
               send_b(16'($urandom), 2'((1 << n) - 1), b == nb - 1);
            end
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
         end
      end
   endtask

   task automatic idle(input int c);
      repeat (c) @(posedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b0;
      a_ivld = 0; a_idata = '0; a_ikeep = '0; a_ilast = 0; a_ordy = 1;
      b_ivld = 0; b_idata = '0; b_ikeep = '0; b_ilast = 0; b_ordy = 1;
      #12;
      check("a_reset_out", 64'({a_ovld, a_odata, a_okeep, a_olast}), 64'd0);
      check("b_reset_out", 64'({b_ovld, b_odata, b_okeep, b_olast}), 64'd0);
      @(posedge clk); #3 rstn = 1'b1;
      #1;
      check("a_irdy_after_reset", 64'(a_irdy), 64'd1);
      check("b_irdy_after_reset", 64'(b_irdy), 64'd1);
      idle(1);

      // Eight single bytes into two full words.
      for (int i = 1; i <= 8; i++) begin
         send_a(8'(i), 1'b1, i == 8);
         if (i == 3) check("a_no_word_yet", 64'(a_ovld), 64'd0);
         if (i == 4) check("a_latency", 64'(a_ovld), 64'd1);
      end
      idle(4);
      check_seen("a_pkt1_w0", 0, 0, {32'h04030201, 4'hF, 1'b0});
      check_seen("a_pkt1_w1", 0, 1, {32'h08070605, 4'hF, 1'b1});

      seen_a.delete();
      send_a(8'hAA, 1'b1, 0); send_a(8'hBB, 1'b1, 0); send_a(8'hCC, 1'b1, 1);
      idle(4);
      check_seen("a_partial", 0, 0, {32'h00CCBBAA, 4'h7, 1'b1});

      // Split at tlast: full word then a one-byte flush word.
      send_b(16'h2211, 2'b11, 0);
      send_b(16'hEE33, 2'b01, 0);
      send_b(16'h5544, 2'b11, 1);
      check("b_flush_irdy_low", 64'(b_irdy), 64'd0);
      idle(1);
      check("b_flush_irdy_back", 64'(b_irdy), 64'd1);
      idle(4);
      check_seen("b_split_w0", 1, 0, {32'h44332211, 4'hF, 1'b0});
      check_seen("b_split_w1", 1, 1, {32'h00000055, 4'h1, 1'b1});

      seen_a.delete();
      a_ordy = 1'b0;
      send_a(8'h11, 1'b1, 0); send_a(8'h22, 1'b1, 0); send_a(8'h33, 1'b1, 0); send_a(8'h44, 1'b1, 0);
      check("a_bp_irdy", 64'(a_irdy), 64'd0);
      fork
         begin
            send_a(8'h55, 1'b1, 0); send_a(8'h66, 1'b1, 0); send_a(8'h77, 1'b1, 0); send_a(8'h88, 1'b1, 1);
         end
         begin
            idle(5);
            check("a_bp_held", 64'({a_ovld, a_odata}), 64'({1'b1, 32'h44332211}));
            a_ordy = 1'b1;
         end
      join
      idle(4);
      check_seen("a_bp_w0", 0, 0, {32'h44332211, 4'hF, 1'b0});
      check_seen("a_bp_w1", 0, 1, {32'h88776655, 4'hF, 1'b1});

      seen_a.delete();
      send_a(8'h5A, 1'b0, 1);
      idle(3);
      check("a_empty_last", 64'(seen_a.size()), 64'd0);
      send_a(8'h01, 1'b1, 0); send_a(8'hFF, 1'b0, 0); send_a(8'h02, 1'b1, 0);
      send_a(8'h03, 1'b1, 0); send_a(8'h04, 1'b1, 1);
      idle(4);
      check_seen("a_keep0_mid", 0, 0, {32'h04030201, 4'hF, 1'b1});

      // Reset mid-packet with a held word on one instance and cnt=2 on the other.
      seen_a.delete(); seen_b.delete();
      a_ordy = 1'b0; b_ordy = 1'b0;
      fork
         begin send_a(8'h01, 1'b1, 0); send_a(8'h02, 1'b1, 0); send_a(8'h03, 1'b1, 0); send_a(8'h04, 1'b1, 0); end
         send_b(16'h2211, 2'b11, 0);
      join
      check("a_held_before_reset", 64'(a_ovld), 64'd1);
      #2 rstn = 1'b0;
      #1;
      check("a_async_reset", 64'({a_ovld, a_odata, a_okeep, a_olast}), 64'd0);
      check("b_async_reset", 64'({b_ovld, b_odata, b_okeep, b_olast}), 64'd0);
      @(negedge clk); @(posedge clk); #3 rstn = 1'b1;
      a_ordy = 1'b1; b_ordy = 1'b1;
      #1;
      check("a_irdy_rerelease", 64'(a_irdy), 64'd1);
      check("b_irdy_rerelease", 64'(b_irdy), 64'd1);
      idle(1);
      send_b(16'hAB77, 2'b01, 1);
      send_a(8'h99, 1'b1, 1);
      idle(4);
      check_seen("b_after_reset", 1, 0, {32'h00000077, 4'h1, 1'b1});
      check_seen("a_after_reset", 0, 0, {32'h00000099, 4'h1, 1'b1});

      rand_bp = 1;
      fork
         rand_packets(0, 150);
         rand_packets(1, 150);
      join
      rand_bp = 0;
      idle(1);
      a_ordy = 1'b1; b_ordy = 1'b1;
      idle(20);
      check("a_drained", 64'(exp_a.size()), 64'd0);
      check("b_drained", 64'(exp_b.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
